// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the multiply / HI-LO unit: ALU opcodes,
// writeback-source selectors and the multiplier FSM state type.
package cpu_pkg;

  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;

  localparam logic [1:0] REGSEL_NONE = 2'd0;
  localparam logic [1:0] REGSEL_HI   = 2'd1;
  localparam logic [1:0] REGSEL_LO   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_seq_core.sv
// Shift-add sequential multiplier core. Converts operands to magnitudes
// when signed, then adds one multiplier bit per cycle (LSB first) into a
// 2*WIDTH accumulator. The sign of the result is applied by the caller.
module mult_seq_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_t        state_q, state_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
  end

  // Next-state and datapath: load on start, shift-add in RUN, hand off in FIN.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == FIN);
  assign product_o = acc_q;

endmodule

// File: rtl/mult_hilo_unit.sv
// Multiply unit with architectural HI/LO registers and HI/LO hazard stall.
// Default build: iterative shift-add multiply (WIDTH+1 cycles).
// Define MULT_FAST_EN for a single-cycle combinational multiply with no stall.
module mult_hilo_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enhilo_EX,
  input  logic [3:0]       alu_op,
  input  logic [1:0]       regsel_EX,
  input  logic             GPIO_IN,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_signed;

  assign is_signed = (alu_op == ALU_MULT);

`ifdef MULT_FAST_EN

  logic signed [PW-1:0] prod_s;
  logic        [PW-1:0] prod_u;

  // Full-width product computed in one cycle.
  always_comb begin
    prod_s = $signed(a_i) * $signed(b_i);
    prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
  end

  // HI/LO written at the request edge; done pulses the following cycle.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (enhilo_EX) begin
      {hi_d, lo_d} = is_signed ? prod_s : prod_u;
      done_d       = 1'b1;
    end
  end

  assign busy_o  = 1'b0;
  assign stall_o = 1'b0;

`else

  logic          neg_q, neg_d;
  logic          start;
  logic          core_busy;
  logic          core_done;
  logic [PW-1:0] core_prod;

  assign start = enhilo_EX & ~core_busy;

  mult_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .signed_i (is_signed),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (core_busy),
    .done_o   (core_done),
    .product_o(core_prod)
  );

  // Latch result sign at start; commit signed product to HI/LO in FIN.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    neg_d  = neg_q;
    if (start) neg_d = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    if (core_done) begin
      {hi_d, lo_d} = neg_q ? (~core_prod + PW'(1)) : core_prod;
      done_d       = 1'b1;
    end
  end

  // Sign register for the multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end

  assign busy_o  = core_busy;
  // Only new multiplies and real HI/LO reads wait; GPIO reads pass through.
  assign stall_o = core_busy & (enhilo_EX | (regsel_EX == REGSEL_LO) |
                                ((regsel_EX == REGSEL_HI) & ~GPIO_IN));

`endif

  // Architectural HI/LO and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Testbench for mult_hilo_unit (default iterative build, WIDTH=32).
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enhilo_EX;
  logic [3:0]  alu_op;
  logic [1:0]  regsel_EX;
  logic        GPIO_IN;
  logic [31:0] a_i, b_i;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o, stall_o;

  int n_cmp = 0;
  int n_bad = 0;

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .enhilo_EX(enhilo_EX),
    .alu_op   (alu_op),
    .regsel_EX(regsel_EX),
    .GPIO_IN  (GPIO_IN),
    .a_i      (a_i),
    .b_i      (b_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  // Reference: the mathematical product of the operands as 64-bit value.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and return at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    a_i       = a;
    b_i       = b;
    alu_op    = sgn ? 4'b0110 : 4'b0111;
    enhilo_EX = 1'b1;
    @(negedge clk);
  endtask

  // Wait for done_o, counting cycles from the current negedge (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn);
    logic [63:0] e;
    int n;
    e = ref_prod(a, b, sgn);
    issue(a, b, sgn);
    enhilo_EX = 1'b0;
    check({tag, ".busy"}, 64'(busy_o), 64'd1);
    wait_done(n);
    check({tag, ".latency"}, 64'(n), 64'd33);
    check({tag, ".hi"}, 64'(hi_o), 64'(e[63:32]));
    check({tag, ".lo"}, 64'(lo_o), 64'(e[31:0]));
    check({tag, ".idle_at_done"}, 64'(busy_o), 64'd0);
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int n;
    int seen_done;
    logic [63:0] e1, e2;
    logic [31:0] ra, rb;
    bit rs;

    rst = 1'b1; enhilo_EX = 1'b0; alu_op = 4'b0; regsel_EX = 2'd0;
    GPIO_IN = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    regsel_EX = 2'd2;
    check("reset.hi", 64'(hi_o), 64'd0);
    check("reset.lo", 64'(lo_o), 64'd0);
    check("reset.busy", 64'(busy_o), 64'd0);
    check("reset.done", 64'(done_o), 64'd0);
    check("reset.stall", 64'(stall_o), 64'd0);
    regsel_EX = 2'd0;

    // Directed products
    run_mult("multu7x6", 32'd7, 32'd6, 1'b0);
    run_mult("mult_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_mult("multu_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mult("mult_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_mult("mult_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_mult("mult_min_x1", 32'h8000_0000, 32'd1, 1'b1);

    // mflo right after the mult stalls for the full latency
    issue(32'd7, 32'd6, 1'b0);
    enhilo_EX = 1'b0;
    regsel_EX = 2'd2;
    n = 0;
    while (stall_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mflo.stall_cycles", 64'(n), 64'd33);
    check("mflo.lo", 64'(lo_o), 64'd42);
    check("mflo.done", 64'(done_o), 64'd1);
    regsel_EX = 2'd0;
    @(negedge clk);

    // Stall qualification while busy
    issue(32'd100, 32'd3, 1'b0);
    enhilo_EX = 1'b0;
    regsel_EX = 2'd1; GPIO_IN = 1'b1; #1;
    check("gpio_read.stall", 64'(stall_o), 64'd0);
    GPIO_IN = 1'b0; #1;
    check("mfhi.stall", 64'(stall_o), 64'd1);
    regsel_EX = 2'd0; #1;
    check("other.stall", 64'(stall_o), 64'd0);
    enhilo_EX = 1'b1; alu_op = 4'b0110; #1;
    check("mult_busy.stall", 64'(stall_o), 64'd1);
    enhilo_EX = 1'b0;
    wait_done(n);
    check("gpio_mult.latency", 64'(n), 64'd33);
    check("gpio_mult.lo", 64'(lo_o), 64'd300);
    @(negedge clk);

    // Reset in the middle of RUN
    issue(32'h0001_2345, 32'h0000_0777, 1'b0);
    enhilo_EX = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    regsel_EX = 2'd2;
    check("rst_mid.hi", 64'(hi_o), 64'd0);
    check("rst_mid.lo", 64'(lo_o), 64'd0);
    check("rst_mid.busy", 64'(busy_o), 64'd0);
    check("rst_mid.done", 64'(done_o), 64'd0);
    check("rst_mid.stall", 64'(stall_o), 64'd0);
    regsel_EX = 2'd0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) seen_done++;
    end
    check("rst_mid.no_done", 64'(seen_done), 64'd0);
    run_mult("post_rst_2x2", 32'd2, 32'd2, 1'b1);

    // Back-to-back: second request held until first result is visible
    e1 = ref_prod(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    e2 = ref_prod(32'hFFFF_FF00, 32'h0000_1001, 1'b1);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    a_i = 32'hFFFF_FF00; b_i = 32'h0000_1001; alu_op = 4'b0110; enhilo_EX = 1'b1;
    n = 0;
    while (stall_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b.stall_cycles", 64'(n), 64'd33);
    check("b2b.first_hi", 64'(hi_o), 64'(e1[63:32]));
    check("b2b.first_lo", 64'(lo_o), 64'(e1[31:0]));
    @(negedge clk);
    enhilo_EX = 1'b0;
    check("b2b.second_busy", 64'(busy_o), 64'd1);
    wait_done(n);
    check("b2b.second_latency", 64'(n), 64'd33);
    check("b2b.second_hi", 64'(hi_o), 64'(e2[63:32]));
    check("b2b.second_lo", 64'(lo_o), 64'(e2[31:0]));
    @(negedge clk);

    // Randomized operands and signedness
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_mult("random", ra, rb, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
